cmd_dispatch_queues: RTL and testbench



---
 rtl/cmd_dispatch_queues_pkg.sv | 30 +++
 rtl/cmd_dispatch_queues_target_fifo.sv | 47 ++++
 rtl/cmd_dispatch_queues.sv | 167 ++++++++++++++++
 tb/tb_cmd_dispatch_queues.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatch_queues_pkg.sv
// Shared definitions for the command dispatch queues: op codes, command field
// positions, FSM state encoding and the second-micro-command flag position.
package cmd_dispatch_queues_pkg;

  localparam int CMD_W     = 128;
  localparam int NUM_UNITS = 16;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b10;
  localparam logic [1:0] OP_ERASE   = 2'b11;

  localparam int OP_MSB    = 127;
  localparam int TGT_MSB   = 125;
  localparam int RAMID_MSB = 122;
  localparam int RAMID_LSB = 119;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ALLOC       = 2'd1,
    S_PUSH_FIRST  = 2'd2,
    S_PUSH_SECOND = 2'd3
  } state_e;

  // Bit that marks the second micro-command of a read; sits just above the address.
  function automatic int second_flag_bit(input int addr_width);
    return 64 + addr_width;
  endfunction

endpackage

// File: rtl/cmd_dispatch_queues_target_fifo.sv
// Single-clock 128-bit command FIFO for one flash target; exposes its free-entry
// count so the dispatcher can reserve room for both halves of a read.
module cmd_target_fifo
  import cmd_dispatch_queues_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [CMD_W-1:0]              push_data,
  input  logic                          pop,
  output logic [CMD_W-1:0]              head_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign free_cnt  = (AW+1)'(FIFO_DEPTH) - count;
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cmd_dispatch_queues.sv
// Host command dispatcher: allocates data-buffer RAM units, splits reads into two
// micro-commands and queues them per target. Optional DISPATCH_STATS_EN adds counters.
module cmd_dispatch_queues
  import cmd_dispatch_queues_pkg::*;
#(
  parameter int ADDR_WIDTH  = 29,
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_TARGETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_in_valid,
  output logic         cmd_in_ready,
  input  logic [127:0] cmd_in,
  input  logic [2:0]   FIFO_addr,
  input  logic         FIFO_rd_en,
  output logic         FIFO_empty,
  output logic [127:0] Cmd_Out,
  input  logic         Set_Empty,
  input  logic [3:0]   Set_Empty_ID,
  input  logic         rd_release,
  input  logic [3:0]   rd_release_id,
  output logic         illegal_cmd
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]  stat_rd_cnt,
  output logic [15:0]  stat_wr_cnt,
  output logic [15:0]  stat_er_cnt,
  output logic [15:0]  stat_stall_cycles
`endif
);

  localparam int FLAG_BIT = second_flag_bit(ADDR_WIDTH);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;

  state_e                 state, next_state;
  logic [CMD_W-1:0]       cmd_p0;
  logic [NUM_UNITS-1:0]   busy_q, rel_mask, alloc_mask;
  logic [3:0]             free_id;
  logic                   free_found;
  logic [1:0]             op_q;
  logic [2:0]             tgt_q;
  logic                   needs_unit, space_ok, alloc_go, alloc_fire, stalled, push_any;
  logic [CMD_W-1:0]       push_data;
  logic [CW-1:0]          free_cnt [NUM_TARGETS];
  logic [CMD_W-1:0]       head     [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] empty_v, push_v, pop_v;

  assign op_q       = cmd_p0[OP_MSB -: 2];
  assign tgt_q      = cmd_p0[TGT_MSB -: 3];
  assign needs_unit = (op_q == OP_READ) || (op_q == OP_WRITE);
  assign space_ok   = (op_q == OP_READ) ? (free_cnt[tgt_q] >= CW'(2))
                                        : (free_cnt[tgt_q] >= CW'(1));
  assign alloc_go   = space_ok && (!needs_unit || free_found);
  assign alloc_fire = (state == S_ALLOC) && (op_q != OP_ILLEGAL) && alloc_go;
  assign stalled    = (state == S_ALLOC) && (op_q != OP_ILLEGAL) && !alloc_go;

  // Lowest-numbered free RAM unit wins.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_id    = 4'(i);
      end
    end
  end

  always_comb begin
    rel_mask = '0;
    if (Set_Empty)  rel_mask[Set_Empty_ID]  = 1'b1;
    if (rd_release) rel_mask[rd_release_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_in_ready <= 1'b0;
      busy_q       <= '0;
    end else begin
      state        <= next_state;
      cmd_in_ready <= (next_state == S_IDLE);
      busy_q       <= (busy_q & ~rel_mask) | alloc_mask;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:        if (cmd_in_valid && cmd_in_ready) next_state = S_ALLOC;
      S_ALLOC:       if (op_q == OP_ILLEGAL)           next_state = S_IDLE;
                     else if (alloc_go)                next_state = S_PUSH_FIRST;
      S_PUSH_FIRST:  next_state = (op_q == OP_READ) ? S_PUSH_SECOND : S_IDLE;
      S_PUSH_SECOND: next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  always_comb begin
    illegal_cmd = (state == S_ALLOC) && (op_q == OP_ILLEGAL);
    alloc_mask  = (alloc_fire && needs_unit) ? (16'b1 << free_id) : '0;
    push_any    = (state == S_PUSH_FIRST) || (state == S_PUSH_SECOND);
    push_data   = cmd_p0;
    push_data[FLAG_BIT] = (state == S_PUSH_SECOND);
  end

  // Stage p0: latched host command, RAM ID stamped in at allocation.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && cmd_in_valid && cmd_in_ready)
      cmd_p0 <= cmd_in;
    else if (alloc_fire)
      cmd_p0[RAMID_MSB:RAMID_LSB] <= needs_unit ? free_id : 4'd0;
  end

  for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_fifo
    assign push_v[t] = push_any && (tgt_q == 3'(t));
    assign pop_v[t]  = FIFO_rd_en && (FIFO_addr == 3'(t));
    cmd_target_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_v[t]),
      .push_data (push_data),
      .pop       (pop_v[t]),
      .head_data (head[t]),
      .empty     (empty_v[t]),
      .free_cnt  (free_cnt[t])
    );
  end

  // Scheduler view: registered head of the selected FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Cmd_Out    <= '0;
      FIFO_empty <= 1'b1;
    end else begin
      Cmd_Out    <= head[FIFO_addr];
      FIFO_empty <= empty_v[FIFO_addr];
    end
  end

`ifdef DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rd_cnt       <= '0;
      stat_wr_cnt       <= '0;
      stat_er_cnt       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (state == S_PUSH_FIRST) begin
        if (op_q == OP_READ)  stat_rd_cnt <= sat_inc(stat_rd_cnt);
        if (op_q == OP_WRITE) stat_wr_cnt <= sat_inc(stat_wr_cnt);
        if (op_q == OP_ERASE) stat_er_cnt <= sat_inc(stat_er_cnt);
      end
      if (stalled) stat_stall_cycles <= sat_inc(stat_stall_cycles);
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stalled;
`endif

endmodule

// File: tb/tb_cmd_dispatch_queues.sv
// Scoreboard bench for cmd_dispatch_queues: directed commands push expected FIFO
// entries; a monitor compares Cmd_Out against them on every scheduler pop.
module tb_cmd_dispatch_queues;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_in_valid;
  logic         cmd_in_ready;
  logic [127:0] cmd_in;
  logic [2:0]   FIFO_addr;
  logic         FIFO_rd_en;
  logic         FIFO_empty;
  logic [127:0] Cmd_Out;
  logic         Set_Empty;
  logic [3:0]   Set_Empty_ID;
  logic         rd_release;
  logic [3:0]   rd_release_id;
  logic         illegal_cmd;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [2:0] tgt; logic [127:0] word; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cmd_dispatch_queues dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_in_valid  (cmd_in_valid),
    .cmd_in_ready  (cmd_in_ready),
    .cmd_in        (cmd_in),
    .FIFO_addr     (FIFO_addr),
    .FIFO_rd_en    (FIFO_rd_en),
    .FIFO_empty    (FIFO_empty),
    .Cmd_Out       (Cmd_Out),
    .Set_Empty     (Set_Empty),
    .Set_Empty_ID  (Set_Empty_ID),
    .rd_release    (rd_release),
    .rd_release_id (rd_release_id),
    .illegal_cmd   (illegal_cmd)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mk(input logic [1:0] op, input logic [2:0] tgt,
                                      input logic [3:0] id, input logic flag,
                                      input logic [31:0] pl);
    logic [127:0] w;
    w = '0;
    w[127:126] = op;
    w[125:123] = tgt;
    w[122:119] = id;
    w[93]      = flag;
    w[31:0]    = pl;
    return w;
  endfunction

  function automatic int count_for(input logic [2:0] t);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].tgt == t) n++;
    return n;
  endfunction

  // Monitor: every pop must hit a non-empty FIFO whose head matches the oldest expectation.
  always @(negedge clk) begin : monitor
    int idx;
    if (FIFO_rd_en) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].tgt == FIFO_addr) idx = i;
      if (FIFO_empty) begin
        checks++; errors++;
        $display("FAIL pop_nonempty tgt=%0d actual=empty required=entry", FIFO_addr);
      end else if (idx < 0) begin
        checks++; errors++;
        $display("FAIL pop_expected tgt=%0d actual=%h required=none", FIFO_addr, Cmd_Out);
      end else begin
        check("cmd_out", Cmd_Out, exp_q[idx].word);
        exp_q.delete(idx);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] c);
    int k = 0;
    while (!cmd_in_ready && k < 200) begin tick(1); k++; end
    if (!cmd_in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=ready0 required=ready1");
    end
    cmd_in = c;
    cmd_in_valid = 1'b1;
    tick(1);
    cmd_in_valid = 1'b0;
  endtask

  task automatic expect_cmd(input logic [1:0] op, input logic [2:0] t,
                            input logic [3:0] id, input logic [31:0] pl);
    exp_q.push_back('{tgt: t, word: mk(op, t, (op == 2'b11) ? 4'd0 : id, 1'b0, pl)});
    if (op == 2'b00) exp_q.push_back('{tgt: t, word: mk(op, t, id, 1'b1, pl)});
  endtask

  task automatic pop_one();
    FIFO_rd_en = 1'b1;
    tick(1);
    FIFO_rd_en = 1'b0;
    tick(1);
  endtask

  task automatic drain(input logic [2:0] t);
    int n;
    FIFO_addr = t;
    tick(2);
    n = count_for(t);
    repeat (n) pop_one();
    check($sformatf("drained_empty_%0d", t), FIFO_empty, 1'b1);
  endtask

  task automatic release_all();
    for (int u = 0; u < 16; u++) begin
      Set_Empty = 1'b1; Set_Empty_ID = 4'(u);
      tick(1);
    end
    Set_Empty = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   cmd_in_ready, 1'b0);
    check({tag, "_empty"},   FIFO_empty,   1'b1);
    check({tag, "_cmd_out"}, Cmd_Out,      128'd0);
    check({tag, "_illegal"}, illegal_cmd,  1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_in_valid = 1'b0; cmd_in = '0; FIFO_addr = 3'd3; FIFO_rd_en = 1'b0;
    Set_Empty = 1'b0; Set_Empty_ID = '0; rd_release = 1'b0; rd_release_id = '0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);
    check("ready_after_reset", cmd_in_ready, 1'b1);

    // Write to target 3 takes unit 0; first visible three edges after acceptance.
    send(mk(2'b01, 3'd3, 4'd0, 1'b0, 32'hA0A0_0003));
    expect_cmd(2'b01, 3'd3, 4'd0, 32'hA0A0_0003);
    check("ready_drop", cmd_in_ready, 1'b0);
    tick(2);
    check("latency_n2_empty", FIFO_empty, 1'b1);
    tick(1);
    check("latency_n3_empty", FIFO_empty, 1'b0);
    check("latency_n3_head", Cmd_Out, mk(2'b01, 3'd3, 4'd0, 1'b0, 32'hA0A0_0003));
    drain(3'd3);

    // Read to target 5: unit 0 still busy so it gets unit 1, two halves.
    send(mk(2'b00, 3'd5, 4'd0, 1'b0, 32'hB0B0_0005));
    expect_cmd(2'b00, 3'd5, 4'd1, 32'hB0B0_0005);
    tick(4);
    drain(3'd5);
    Set_Empty = 1'b1; Set_Empty_ID = 4'd0; rd_release = 1'b1; rd_release_id = 4'd1;
    tick(1);
    Set_Empty = 1'b0; rd_release = 1'b0;

    // Exhaust all 16 units, then a 17th read stalls until unit 7 is released.
    for (int i = 0; i < 16; i++) begin
      send(mk(2'b00, 3'(i % 8), 4'd0, 1'b0, 32'h1000 + i));
      expect_cmd(2'b00, 3'(i % 8), 4'(i), 32'h1000 + i);
    end
    send(mk(2'b00, 3'd6, 4'd0, 1'b0, 32'h1011));
    tick(5);
    check("pool_stall_ready", cmd_in_ready, 1'b0);
    rd_release = 1'b1; rd_release_id = 4'd7;
    tick(1);
    rd_release = 1'b0;
    expect_cmd(2'b00, 3'd6, 4'd7, 32'h1011);
    tick(4);
    check("pool_resume_ready", cmd_in_ready, 1'b1);
    for (int t = 0; t < 8; t++) drain(3'(t));
    release_all();

    // FIFO0 holds DEPTH-1 entries: a read needs two slots and stalls until a pop.
    FIFO_addr = 3'd0;
    for (int i = 0; i < 7; i++) begin
      send(mk(2'b01, 3'd0, 4'd0, 1'b0, 32'h2000 + i));
      expect_cmd(2'b01, 3'd0, 4'(i), 32'h2000 + i);
    end
    send(mk(2'b00, 3'd0, 4'd0, 1'b0, 32'h3000));
    tick(6);
    check("space_stall_ready", cmd_in_ready, 1'b0);
    check("space_stall_nonempty", FIFO_empty, 1'b0);
    pop_one();
    expect_cmd(2'b00, 3'd0, 4'd7, 32'h3000);
    tick(4);
    check("space_resume_ready", cmd_in_ready, 1'b1);
    drain(3'd0);
    release_all();

    // Illegal op is dropped with a single illegal_cmd pulse.
    FIFO_addr = 3'd2;
    send(mk(2'b10, 3'd2, 4'd0, 1'b0, 32'h4000));
    check("illegal_pulse", illegal_cmd, 1'b1);
    tick(1);
    check("illegal_pulse_end", illegal_cmd, 1'b0);
    check("illegal_ready", cmd_in_ready, 1'b1);
    tick(2);
    check("illegal_no_push", FIFO_empty, 1'b1);

    // Reset while the second half of a read is being written.
    FIFO_addr = 3'd4;
    send(mk(2'b00, 3'd4, 4'd0, 1'b0, 32'h5000));
    tick(2);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      FIFO_addr = 3'(t);
      tick(2);
      check($sformatf("post_reset_empty_%0d", t), FIFO_empty, 1'b1);
    end

    // Unit 0 is free again after reset; erase takes no unit.
    send(mk(2'b01, 3'd1, 4'd0, 1'b0, 32'h6000)); expect_cmd(2'b01, 3'd1, 4'd0, 32'h6000);
    send(mk(2'b01, 3'd1, 4'd0, 1'b0, 32'h6001)); expect_cmd(2'b01, 3'd1, 4'd1, 32'h6001);
    send(mk(2'b11, 3'd7, 4'd0, 1'b0, 32'h6002)); expect_cmd(2'b11, 3'd7, 4'd0, 32'h6002);
    send(mk(2'b01, 3'd7, 4'd0, 1'b0, 32'h6003)); expect_cmd(2'b01, 3'd7, 4'd2, 32'h6003);
    FIFO_addr = 3'd1;
    tick(4);

    // Pop, push and double release of unit 2 all land on the same edge.
    send(mk(2'b01, 3'd1, 4'd0, 1'b0, 32'h6004)); expect_cmd(2'b01, 3'd1, 4'd3, 32'h6004);
    tick(1);
    FIFO_rd_en = 1'b1;
    Set_Empty = 1'b1; Set_Empty_ID = 4'd2; rd_release = 1'b1; rd_release_id = 4'd2;
    tick(1);
    FIFO_rd_en = 1'b0; Set_Empty = 1'b0; rd_release = 1'b0;
    tick(2);
    send(mk(2'b01, 3'd1, 4'd0, 1'b0, 32'h6005)); expect_cmd(2'b01, 3'd1, 4'd2, 32'h6005);
    tick(4);
    drain(3'd1);
    drain(3'd7);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
